// File: rtl/l2_req_scheduler.sv
`timescale 1ns/1ps
// L2 request scheduler: arbitrates buffered L1 requests and a single snoop slot
// onto one outstanding cache access, with statistics and sticky error flags.
module l2_req_scheduler #(
   parameter int L1_DEPTH       = 4,
   parameter int MAX_SNP_STREAK = 4,
   parameter int TIMEOUT        = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        l1_valid,
   output logic        l1_ready,
   input  logic [1:0]  l1_op,
   input  logic [31:0] l1_addr,
   input  logic        snp_valid,
   output logic        snp_ready,
   input  logic [1:0]  snp_op,
   input  logic [31:0] snp_addr,
   output logic        cache_req_valid,
   input  logic        cache_req_ready,
   output logic [2:0]  cache_req_op,
   output logic [31:0] cache_req_addr,
   input  logic        cache_done,
   input  logic        cache_hit,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt,
   output logic [31:0] l1_cnt,
   output logic [31:0] snp_cnt,
   output logic        err_illegal,
   output logic        err_timeout,
   output logic [1:0]  dbg_state
);

   localparam int AW = $clog2(L1_DEPTH);
   localparam int SW = $clog2(MAX_SNP_STREAK + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never waits on ready, and ready depends only on state.
   state_t          state, state_next;
   logic [1:0]      fifo_op   [L1_DEPTH];
   logic [31:0]     fifo_addr [L1_DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic            fifo_empty, fifo_full;
   logic            snp_full;
   logic [1:0]      snp_op_q;
   logic [31:0]     snp_addr_q;
   logic [SW-1:0]   streak;
   logic [TW-1:0]   wait_cnt;
   logic            src_l1;
   logic            l1_fire, l1_push, snp_fire;
   logic            start, grant_l1, done_ok, timeout;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign fifo_empty      = (wr_ptr == rd_ptr);
   assign fifo_full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign l1_ready        = !fifo_full;
   assign snp_ready       = !snp_full;
   assign l1_fire         = l1_valid && l1_ready;
   assign l1_push         = l1_fire && (l1_op != 2'd3);
   assign snp_fire        = snp_valid && snp_ready;
   assign cache_req_valid = (state == ISSUE);
   assign dbg_state       = state;

   always_comb begin
      state_next = state;
      start      = 1'b0;
      grant_l1   = 1'b0;
      done_ok    = 1'b0;
      timeout    = 1'b0;
      case (state)
         IDLE: begin
            if (snp_full || !fifo_empty) begin
               start      = 1'b1;
               grant_l1   = !fifo_empty && (!snp_full || streak == SW'(MAX_SNP_STREAK));
               state_next = ISSUE;
            end
         end
         ISSUE: if (cache_req_ready) state_next = WAIT;
         WAIT: begin
            if (cache_done) begin
               done_ok    = 1'b1;
               state_next = IDLE;
            end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
               timeout    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Payload storage needs no reset; occupancy is governed by the pointers.
   always_ff @(posedge clk) begin
      if (l1_push) begin
         fifo_op[wr_ptr[AW-1:0]]   <= l1_op;
         fifo_addr[wr_ptr[AW-1:0]] <= l1_addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         snp_full   <= 1'b0;
         snp_op_q   <= 2'd0;
         snp_addr_q <= 32'd0;
      end else begin
         if (l1_push)           wr_ptr <= wr_ptr + 1'b1;
         if (start && grant_l1) rd_ptr <= rd_ptr + 1'b1;
         if (snp_fire) begin
            snp_full   <= 1'b1;
            snp_op_q   <= snp_op;
            snp_addr_q <= snp_addr;
         end else if (start && !grant_l1) begin
            snp_full <= 1'b0;
         end
      end
   end

   // Request latch, streak and WAIT timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_req_op   <= 3'd0;
         cache_req_addr <= 32'd0;
         src_l1         <= 1'b0;
         streak         <= '0;
         wait_cnt       <= '0;
      end else begin
         if (start) begin
            src_l1 <= grant_l1;
            if (grant_l1) begin
               cache_req_op   <= {1'b0, fifo_op[rd_ptr[AW-1:0]]};
               cache_req_addr <= fifo_addr[rd_ptr[AW-1:0]];
               streak         <= '0;
            end else begin
               cache_req_op   <= {1'b0, snp_op_q} + 3'd3;
               cache_req_addr <= snp_addr_q;
               if (streak != SW'(MAX_SNP_STREAK)) streak <= streak + 1'b1;
            end
         end
         if (state == ISSUE)     wait_cnt <= '0;
         else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt     <= 32'd0;
         miss_cnt    <= 32'd0;
         l1_cnt      <= 32'd0;
         snp_cnt     <= 32'd0;
         err_illegal <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         if (done_ok) begin
            if (cache_hit) hit_cnt  <= sat_inc(hit_cnt);
            else           miss_cnt <= sat_inc(miss_cnt);
            if (src_l1)    l1_cnt   <= sat_inc(l1_cnt);
            else           snp_cnt  <= sat_inc(snp_cnt);
         end
         if (l1_fire && l1_op == 2'd3) err_illegal <= 1'b1;
         if (timeout)                  err_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_l2_req_scheduler.sv
`timescale 1ns/1ps
// Directed bench for l2_req_scheduler: cache responder with scoreboard of
// expected cache requests, plus hand-computed counter and flag checks.
module tb_l2_req_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        l1_valid = 1'b0;
   logic        l1_ready;
   logic [1:0]  l1_op = 2'd0;
   logic [31:0] l1_addr = 32'd0;
   logic        snp_valid = 1'b0;
   logic        snp_ready;
   logic [1:0]  snp_op = 2'd0;
   logic [31:0] snp_addr = 32'd0;
   logic        cache_req_valid;
   logic        cache_req_ready = 1'b1;
   logic [2:0]  cache_req_op;
   logic [31:0] cache_req_addr;
   logic        cache_done = 1'b0;
   logic        cache_hit = 1'b0;
   logic [31:0] hit_cnt, miss_cnt, l1_cnt, snp_cnt;
   logic        err_illegal, err_timeout;
   logic [1:0]  dbg_state;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_issued = 0;
   int          base;
   logic [34:0] exp_q[$];
   logic [34:0] exp_item;
   logic        resp_en = 1'b1;
   logic        resp_hit = 1'b1;
   int          resp_delay = 3;
   logic        pend = 1'b0;
   int          resp_cnt = 0;

   l2_req_scheduler dut (
      .clk(clk), .rst_n(rst_n),
      .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_op(l1_op), .l1_addr(l1_addr),
      .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
      .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready),
      .cache_req_op(cache_req_op), .cache_req_addr(cache_req_addr),
      .cache_done(cache_done), .cache_hit(cache_hit),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .l1_cnt(l1_cnt), .snp_cnt(snp_cnt),
      .err_illegal(err_illegal), .err_timeout(err_timeout), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Cache model: scoreboard on accepted requests, done pulse resp_delay cycles later.
   initial begin
      forever begin
         @(negedge clk);
         if (cache_req_valid && cache_req_ready) begin
            n_issued++;
            pend = 1'b1;
            resp_cnt = 0;
            if (exp_q.size() == 0) begin
               check("sb_unexpected_req", 32'd1, 32'd0);
            end else begin
               exp_item = exp_q.pop_front();
               check("sb_op", {29'd0, cache_req_op}, {29'd0, exp_item[34:32]});
               check("sb_addr", cache_req_addr, exp_item[31:0]);
            end
         end
         @(posedge clk);
         #1;
         cache_done = 1'b0;
         if (pend && resp_en) begin
            resp_cnt++;
            if (resp_cnt == resp_delay) begin
               cache_done = 1'b1;
               cache_hit  = resp_hit;
               pend       = 1'b0;
            end
         end
      end
   end

   task automatic send_l1(input logic [1:0] op, input logic [31:0] addr);
      l1_valid = 1'b1;
      l1_op    = op;
      l1_addr  = addr;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (l1_ready) begin
            @(posedge clk);
            #1;
            l1_valid = 1'b0;
            return;
         end
      end
      l1_valid = 1'b0;
      check("send_l1_stalled", 32'd1, 32'd0);
   endtask

   task automatic send_snp(input logic [1:0] op, input logic [31:0] addr);
      snp_valid = 1'b1;
      snp_op    = op;
      snp_addr  = addr;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (snp_ready) begin
            @(posedge clk);
            #1;
            snp_valid = 1'b0;
            return;
         end
      end
      snp_valid = 1'b0;
      check("send_snp_stalled", 32'd1, 32'd0);
   endtask

   task automatic wait_issued(input string tag, input int target);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 2000 && !ok; k++) begin
         @(posedge clk);
         #1;
         if (n_issued >= target && dbg_state == 2'd0 && !pend) ok = 1'b1;
      end
      check(tag, {31'd0, ok}, 32'd1);
   endtask

   initial begin
      int wait_cycles;
      logic seen_wait;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_l1_ready", {31'd0, l1_ready}, 32'd1);
      check("rst_snp_ready", {31'd0, snp_ready}, 32'd1);
      check("rst_valid", {31'd0, cache_req_valid}, 32'd0);
      check("rst_op", {29'd0, cache_req_op}, 32'd0);
      check("rst_addr", cache_req_addr, 32'd0);
      check("rst_hit_cnt", hit_cnt, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single L1 read: valid exactly two cycles after acceptance
      base = n_issued;
      exp_q.push_back({3'd0, 32'h0000_1040});
      l1_valid = 1'b1; l1_op = 2'd0; l1_addr = 32'h0000_1040;
      @(posedge clk); #1;
      l1_valid = 1'b0;
      check("lat_n1_valid", {31'd0, cache_req_valid}, 32'd0);
      @(posedge clk); #1;
      check("lat_n2_valid", {31'd0, cache_req_valid}, 32'd1);
      check("lat_n2_op", {29'd0, cache_req_op}, 32'd0);
      check("lat_n2_addr", cache_req_addr, 32'h0000_1040);
      wait_issued("done_single", base + 1);
      check("single_hit_cnt", hit_cnt, 32'd1);
      check("single_miss_cnt", miss_cnt, 32'd0);
      check("single_l1_cnt", l1_cnt, 32'd1);

      // Snoop and L1 in the same cycle: snoop first (RWIM -> op 5), misses
      resp_hit = 1'b0;
      base = n_issued;
      exp_q.push_back({3'd5, 32'h0000_A000});
      exp_q.push_back({3'd1, 32'h0000_B000});
      l1_valid = 1'b1; l1_op = 2'd1; l1_addr = 32'h0000_B000;
      snp_valid = 1'b1; snp_op = 2'd2; snp_addr = 32'h0000_A000;
      @(posedge clk); #1;
      l1_valid = 1'b0; snp_valid = 1'b0;
      wait_issued("done_race", base + 2);
      check("race_miss_cnt", miss_cnt, 32'd2);
      check("race_l1_cnt", l1_cnt, 32'd2);
      check("race_snp_cnt", snp_cnt, 32'd1);

      // Starvation: four snoop grants, then the waiting L1 read, then the next snoop
      resp_hit = 1'b1;
      base = n_issued;
      for (int i = 0; i < 4; i++) exp_q.push_back({3'd3, 32'h0000_C000});
      exp_q.push_back({3'd0, 32'h0000_D000});
      exp_q.push_back({3'd3, 32'h0000_C000});
      l1_valid = 1'b1; l1_op = 2'd0; l1_addr = 32'h0000_D000;
      snp_valid = 1'b1; snp_op = 2'd0; snp_addr = 32'h0000_C000;
      @(posedge clk); #1;
      l1_valid = 1'b0; snp_valid = 1'b0;
      for (int i = 0; i < 4; i++) send_snp(2'd0, 32'h0000_C000);
      wait_issued("done_starve", base + 6);
      check("starve_hit_cnt", hit_cnt, 32'd7);
      check("starve_l1_cnt", l1_cnt, 32'd3);
      check("starve_snp_cnt", snp_cnt, 32'd6);

      // FIFO full and pointer wrap: one entry held in ISSUE plus four buffered
      resp_hit = 1'b0;
      cache_req_ready = 1'b0;
      base = n_issued;
      for (int i = 1; i <= 6; i++) exp_q.push_back({3'd1, 32'(i * 256)});
      for (int i = 1; i <= 5; i++) send_l1(2'd1, 32'(i * 256));
      repeat (2) @(posedge clk);
      #1;
      check("full_l1_ready", {31'd0, l1_ready}, 32'd0);
      check("hold_valid", {31'd0, cache_req_valid}, 32'd1);
      check("hold_op", {29'd0, cache_req_op}, 32'd1);
      check("hold_addr", cache_req_addr, 32'h0000_0100);
      cache_req_ready = 1'b1;
      send_l1(2'd1, 32'h0000_0600);
      wait_issued("done_wrap", base + 6);
      check("wrap_l1_cnt", l1_cnt, 32'd9);
      check("wrap_miss_cnt", miss_cnt, 32'd8);

      // Illegal L1 op: accepted, dropped, flagged
      base = n_issued;
      check("pre_err_illegal", {31'd0, err_illegal}, 32'd0);
      send_l1(2'd3, 32'h0000_DEAD);
      repeat (5) @(posedge clk);
      #1;
      check("err_illegal", {31'd0, err_illegal}, 32'd1);
      check("illegal_not_issued", 32'(n_issued - base), 32'd0);
      check("illegal_state", {30'd0, dbg_state}, 32'd0);

      // Timeout: no completion for 255 WAIT cycles
      resp_en = 1'b0;
      exp_q.push_back({3'd0, 32'h0000_E000});
      send_l1(2'd0, 32'h0000_E000);
      wait_cycles = 0;
      seen_wait = 1'b0;
      for (int k = 0; k < 600; k++) begin
         @(posedge clk);
         #1;
         if (dbg_state == 2'd2) begin
            seen_wait = 1'b1;
            wait_cycles++;
         end else if (seen_wait) begin
            break;
         end
      end
      check("timeout_wait_cycles", 32'(wait_cycles), 32'd255);
      check("err_timeout", {31'd0, err_timeout}, 32'd1);
      check("timeout_state", {30'd0, dbg_state}, 32'd0);
      check("timeout_hit_cnt", hit_cnt, 32'd7);
      check("timeout_miss_cnt", miss_cnt, 32'd8);
      check("timeout_l1_cnt", l1_cnt, 32'd9);
      pend = 1'b0;

      // Stray completion while idle is ignored
      @(posedge clk); #2;
      cache_done = 1'b1; cache_hit = 1'b1;
      @(posedge clk); #2;
      cache_done = 1'b0;
      check("stray_hit_cnt", hit_cnt, 32'd7);
      check("stray_state", {30'd0, dbg_state}, 32'd0);

      // Reset during WAIT abandons the access
      exp_q.push_back({3'd0, 32'h0000_F000});
      send_l1(2'd0, 32'h0000_F000);
      seen_wait = 1'b0;
      for (int k = 0; k < 20 && !seen_wait; k++) begin
         @(posedge clk);
         #1;
         if (dbg_state == 2'd2) seen_wait = 1'b1;
      end
      check("reached_wait", {31'd0, seen_wait}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
      check("mid_rst_valid", {31'd0, cache_req_valid}, 32'd0);
      check("mid_rst_addr", cache_req_addr, 32'd0);
      check("mid_rst_hit_cnt", hit_cnt, 32'd0);
      check("mid_rst_miss_cnt", miss_cnt, 32'd0);
      check("mid_rst_l1_cnt", l1_cnt, 32'd0);
      check("mid_rst_snp_cnt", snp_cnt, 32'd0);
      check("mid_rst_errs", {30'd0, err_illegal, err_timeout}, 32'd0);
      check("mid_rst_readys", {30'd0, l1_ready, snp_ready}, 32'd3);
      pend = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      resp_en = 1'b1;
      resp_hit = 1'b1;
      @(posedge clk); #1;
      check("post_rst_state", {30'd0, dbg_state}, 32'd0);

      // Normal operation after reset: instruction read
      base = n_issued;
      exp_q.push_back({3'd2, 32'h0000_2000});
      send_l1(2'd2, 32'h0000_2000);
      wait_issued("done_post_rst", base + 1);
      check("post_rst_l1_cnt", l1_cnt, 32'd1);
      check("post_rst_hit_cnt", hit_cnt, 32'd1);
      check("post_rst_snp_cnt", snp_cnt, 32'd0);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
